// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Push-button front end for the lamp FSM. Synchronizes the raw
//               button level, debounces it with a 4-state FSM and produces a
//               clean level plus one-cycle press/release pulses.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DEBOUNCE_CYCLES - consecutive stable synchronized samples needed to
//                     accept an edge (>= 2)
//   LONG_CYCLES     - hold cycles in PRESSED before long_press fires
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   B_raw         in   raw, possibly bouncing button level (async to clk)
//   B_clean       out  debounced level (1 in PRESSED / RELEASE_WAIT)
//   press         out  one-cycle pulse on accepted press
//   release_pulse out  one-cycle pulse on accepted release
//                      ("release" is a reserved word in SystemVerilog)
//   s1, s0        out  FSM state bits
//   long_press    out  one-cycle long-hold pulse (only with BTN_LONG_PRESS_EN)
// Optional feature macro: BTN_LONG_PRESS_EN
// ============================================================================
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic B_raw,
  output logic B_clean,
  output logic press,
  output logic release_pulse,
  output logic s1,
  output logic s0
`ifdef BTN_LONG_PRESS_EN
  ,
  output logic long_press
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Gray-like encoding: s1 doubles as the debounced level.
  localparam logic [1:0] C_IDLE         = 2'b00;
  localparam logic [1:0] C_PRESS_WAIT   = 2'b01;
  localparam logic [1:0] C_PRESSED      = 2'b11;
  localparam logic [1:0] C_RELEASE_WAIT = 2'b10;

  logic             r_sync1;
  logic             r_sync2;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_press;
  logic             r_release;
  logic             w_press_nxt;
  logic             w_release_nxt;

  // Two-flop synchronizer; only r_sync2 is used downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= B_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state logic. The counter restarts from zero on every state change.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      C_IDLE: begin
        if (r_sync2) begin
          w_state_nxt = C_PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      C_PRESS_WAIT: begin
        if (!r_sync2) begin
          w_state_nxt = C_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt = C_PRESSED;
          w_cnt_nxt   = '0;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      C_PRESSED: begin
        if (!r_sync2) begin
          w_state_nxt = C_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      default: begin // C_RELEASE_WAIT
        if (r_sync2) begin
          w_state_nxt = C_PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt   = C_IDLE;
          w_cnt_nxt     = '0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= C_IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // All outputs come straight from flops.
  assign s1            = r_state[1];
  assign s0            = r_state[0];
  assign B_clean       = r_state[1];
  assign press         = r_press;
  assign release_pulse = r_release;

`ifdef BTN_LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] C_HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] C_HOLD_SAT  = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] r_hold;
  logic              r_long;

  // Held at zero while waiting for a press, so a fresh PRESSED entry starts
  // from zero. RELEASE_WAIT neither clears nor counts, so a release bounce
  // resumes the same hold. Saturation at LONG_CYCLES gives one pulse per hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold <= '0;
      r_long <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (r_state == C_PRESS_WAIT || w_state_nxt == C_IDLE) begin
        r_hold <= '0;
      end else if (r_state == C_PRESSED && r_hold != C_HOLD_SAT) begin
        r_hold <= r_hold + HOLD_W'(1);
        if (r_hold == C_HOLD_FIRE) begin
          r_long <= 1'b1;
        end
      end
    end
  end

  assign long_press = r_long;
`endif

endmodule
`default_nettype wire
